// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch stage. Drives the fetch PC to a combinational
//             instruction memory, captures the returned word and buffers
//             {pc, instr} pairs in a DEPTH-entry FIFO towards decode.
//             Supports redirect with queue flush and a fetch-enable hold.
//  Ports    : clk            - clock, rising edge
//             reset          - asynchronous active-low reset
//             fetch_en       - 1: fetch may advance, 0: hold fetch PC
//             imem_addr      - byte address to instruction memory (fetch PC)
//             imem_data      - instruction word for imem_addr (same cycle)
//             redirect_valid - jump/branch taken this cycle (flushes queue)
//             redirect_pc    - new fetch address, low two bits ignored
//             out_valid      - instruction presented to decode
//             out_ready      - decode accepts this cycle
//             out_instr      - presented instruction word
//             out_pc         - byte address of out_instr
//             count          - queue occupancy
//  Config   : FETCH_QUEUE_BYPASS_EN - when defined, an empty queue forwards
//             imem_data straight to decode in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_en,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_data,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned         c_ptr_w = $clog2(DEPTH);
   localparam int unsigned         c_cnt_w = $clog2(DEPTH+1);
   localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);

   logic [31:0]        r_fetch_pc;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               r_out_valid;
   logic [31:0]        r_out_instr;
   logic [31:0]        r_out_pc;
   logic [31:0]        r_mem_pc    [DEPTH];
   logic [31:0]        r_mem_instr [DEPTH];

   logic               w_bypass_show;
   logic               w_bypass_take;
   logic               w_pop_q;
   logic               w_enq;
   logic               w_pc_adv;
   logic [c_cnt_w-1:0] w_left;
   logic [c_cnt_w-1:0] w_count_nxt;
   logic [c_ptr_w-1:0] w_rd_nxt;
   logic [31:0]        w_head_pc;
   logic [31:0]        w_head_instr;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue: present the memory word directly to decode.
   assign w_bypass_show = (r_count == '0) && !redirect_valid && fetch_en;
`else
   assign w_bypass_show = 1'b0;
`endif
   assign w_bypass_take = w_bypass_show & out_ready;

   assign imem_addr = r_fetch_pc;
   assign count     = r_count;
   assign out_valid = w_bypass_show | r_out_valid;
   assign out_instr = w_bypass_show ? imem_data  : r_out_instr;
   assign out_pc    = w_bypass_show ? r_fetch_pc : r_out_pc;

   // r_out_valid is high exactly when the queue holds an entry, so a queue
   // pop never coincides with a bypass transfer.
   assign w_pop_q  = r_out_valid & out_ready;
   assign w_enq    = fetch_en & ~redirect_valid & ~w_bypass_take &
                     ((r_count != c_depth) | w_pop_q);
   assign w_pc_adv = w_enq | w_bypass_take;

   assign w_left      = r_count - c_cnt_w'(w_pop_q);
   assign w_count_nxt = w_left + c_cnt_w'(w_enq);
   assign w_rd_nxt    = r_rd_ptr + c_ptr_w'(w_pop_q);

   // Next head: if nothing remains after the pop, the head is the word being
   // enqueued now; otherwise it is the stored entry at the advanced read
   // pointer (never the slot being overwritten, since DEPTH >= 2).
   always_comb begin
      w_head_pc    = r_mem_pc[w_rd_nxt];
      w_head_instr = r_mem_instr[w_rd_nxt];
      if (w_left == '0) begin
         w_head_pc    = r_fetch_pc;
         w_head_instr = imem_data;
      end
   end

   // Storage array carries data only, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
         r_mem_instr[r_wr_ptr] <= imem_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc  <= RESET_PC;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_pc    <= '0;
      end else if (redirect_valid) begin
         // A same-cycle pop has already been delivered; then flush.
         r_fetch_pc  <= redirect_pc & 32'hFFFF_FFFC;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_pc_adv) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         r_rd_ptr    <= w_rd_nxt;
         r_count     <= w_count_nxt;
         r_out_valid <= (w_count_nxt != '0);
         if (w_count_nxt != '0) begin
            r_out_instr <= w_head_instr;
            r_out_pc    <= w_head_pc;
         end
      end
   end

endmodule
`default_nettype wire
